// File: rtl/key_schedule_unit_pkg.sv
// Shared AES definitions: key types, round count, S-box and xtime helpers.
// Also provides the NUM_ROUNDS/TRUE/FALSE macros used across the AES datapath.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package AESDefinitions;

    typedef logic [127:0] key_t;
    typedef logic [127:0] roundKey_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 in GF(2^8), followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_schedule_unit_step.sv
// One AES-128 key expansion round: nextKey = step(prevKey, rcon). Purely combinational.
module key_expansion_step
    import AESDefinitions::*;
(
    input  key_t       prevKey,
    input  logic [7:0] rcon,
    output key_t       nextKey
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prevKey[127:96];
    assign w1 = prevKey[95:64];
    assign w2 = prevKey[63:32];
    assign w3 = prevKey[31:0];

    // SubWord(RotWord(w3)) with the round constant folded into the top byte
    assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon, 24'h0};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign nextKey = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_unit.sv
// Iterative AES-128 key expansion: one round key per clock into a register file with a registered read port.
// Optional KEY_SCHED_ZEROIZE_EN: key storage is cleared on reset and on each accepted load.
module key_schedule_unit
    import AESDefinitions::*;
#(
    parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  key_t       cipherKey,
    output logic       busy,
    output logic       ready,
    input  logic [3:0] rdIndex,
    output roundKey_t  rdKey,
    output logic       rdValid
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_t  state, state_n;
    logic       accept;
    logic       step_we;
    logic [3:0] cnt;
    logic [7:0] rcon;
    key_t       keys [0:NUM_ROUNDS];
    key_t       prev_key;
    key_t       next_key;
    key_t       rd_mux;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Load is ignored while expanding; reset suppresses both load and the round write.
    always_comb begin
        state_n = state;
        accept  = `FALSE;
        step_we = `FALSE;
        if (!reset) begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        accept  = `TRUE;
                        state_n = EXPAND;
                    end
                end
                EXPAND: begin
                    step_we = `TRUE;
                    if (cnt == LAST_IDX) state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy  = (state == EXPAND);
    assign ready = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= 4'd0;
            rcon <= 8'h01;
        end else if (accept) begin
            cnt  <= 4'd1;
            rcon <= 8'h01;
        end else if (step_we) begin
            cnt  <= cnt + 4'd1;
            rcon <= xtime(rcon);
        end
    end

    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (cnt == 4'(i + 1)) prev_key = keys[i];
        end
    end

    key_expansion_step u_step (
        .prevKey (prev_key),
        .rcon    (rcon),
        .nextKey (next_key)
    );

    for (genvar g = 0; g <= NUM_ROUNDS; g++) begin : g_key
        key_t key_q;

        always_ff @(posedge clock) begin
`ifdef KEY_SCHED_ZEROIZE_EN
            if (reset) begin
                key_q <= '0;
            end else
`endif
            if (accept) begin
                if (g == 0) begin
                    key_q <= cipherKey;
                end
`ifdef KEY_SCHED_ZEROIZE_EN
                else begin
                    key_q <= '0;
                end
`endif
            end else if (step_we && (g != 0) && (cnt == 4'(g))) begin
                key_q <= next_key;
            end
        end

        assign keys[g] = key_q;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rdIndex == 4'(i)) rd_mux = keys[i];
        end
    end

    // Registered read: an index written on the same edge returns its previous contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdKey   <= '0;
            rdValid <= 1'b0;
        end else begin
            rdKey   <= (rdIndex <= LAST_IDX) ? rd_mux : '0;
            rdValid <= ready && (rdIndex <= LAST_IDX);
        end
    end

endmodule

// File: tb/tb_key_schedule_unit.sv
// Bench for key_schedule_unit: directed AES-128 vectors plus random keys checked against a word-level FIPS-197 model.
module tb_key_schedule_unit;
    import AESDefinitions::*;

    localparam int NR = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    key_t       cipherKey;
    logic       busy;
    logic       ready;
    logic [3:0] rdIndex;
    roundKey_t  rdKey;
    logic       rdValid;

    int total = 0;
    int bad   = 0;

    key_t exp_q[$];

    logic [0:2047] sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    always #5 clock = ~clock;

    key_schedule_unit #(.NUM_ROUNDS(NR)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .cipherKey (cipherKey),
        .busy      (busy),
        .ready     (ready),
        .rdIndex   (rdIndex),
        .rdKey     (rdKey),
        .rdValid   (rdValid)
    );

    function automatic logic [7:0] sb(input logic [7:0] b);
        return sbox_bits[int'(b) * 8 +: 8];
    endfunction

    // FIPS-197 word schedule w[0..43]; round key r is w[4r..4r+3].
    task automatic build_model(input key_t k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0)
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])}
                    ^ {rcon_tbl[i / 4 - 1], 24'h0};
            w[i] = w[i - 4] ^ t;
        end
        exp_q.delete();
        for (int r = 0; r <= NR; r++) exp_q.push_back({w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]});
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic key_t rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Load a key and follow the expansion edge by edge; optionally pulse a stray load mid-way.
    task automatic run_load(input key_t k, input int glitch_at);
        build_model(k);
        load      = 1'b1;
        cipherKey = k;
        tick();
        load      = 1'b0;
        cipherKey = rand_key();
        check("busy_on_accept", 128'(busy), 128'(1));
        check("ready_drop_on_accept", 128'(ready), 128'(0));
        for (int c = 1; c <= NR; c++) begin
            if (c == glitch_at) begin
                load      = 1'b1;
                cipherKey = rand_key();
            end
            tick();
            load = 1'b0;
            check($sformatf("ready_cycle%0d", c), 128'(ready), 128'(c == NR));
            check($sformatf("busy_cycle%0d", c), 128'(busy), 128'(c < NR));
        end
    endtask

    task automatic read_model(input int idx);
        rdIndex = 4'(idx);
        tick();
        check($sformatf("rdkey_idx%0d", idx), rdKey, (idx <= NR) ? exp_q[idx] : 128'h0);
        check($sformatf("rdvalid_idx%0d", idx), 128'(rdValid), 128'(idx <= NR));
    endtask

    task automatic read_lit(input int idx, input key_t v);
        rdIndex = 4'(idx);
        tick();
        check($sformatf("vector_idx%0d", idx), rdKey, v);
        check($sformatf("vector_valid_idx%0d", idx), 128'(rdValid), 128'(1));
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        cipherKey = '0;
        rdIndex   = 4'd0;

        // Reset for two cycles, then scan the read port
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_ready", 128'(ready), 128'(0));
        check("reset_rdvalid", 128'(rdValid), 128'(0));
        check("reset_rdkey", rdKey, 128'h0);
        for (int i = 0; i <= NR; i++) begin
            rdIndex = 4'(i);
            tick();
            check($sformatf("idle_rdvalid_idx%0d", i), 128'(rdValid), 128'(0));
`ifdef KEY_SCHED_ZEROIZE_EN
            check($sformatf("idle_rdkey_idx%0d", i), rdKey, 128'h0);
`endif
        end

        // FIPS-197 appendix vector 000102..0F
        run_load(128'h000102030405060708090a0b0c0d0e0f, 0);
        read_lit(1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read_lit(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Restart from DONE with the 2B7E.. vector
        run_load(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        read_lit(1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_lit(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_lit(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Stray load four cycles into an expansion is ignored
        run_load(128'h000102030405060708090a0b0c0d0e0f, 4);
        read_lit(1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read_lit(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset five cycles into an expansion, with a simultaneous load that must be dropped
        load      = 1'b1;
        cipherKey = rand_key();
        tick();
        load = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        reset     = 1'b1;
        load      = 1'b1;
        cipherKey = rand_key();
        tick();
        reset = 1'b0;
        load  = 1'b0;
        check("midreset_busy", 128'(busy), 128'(0));
        check("midreset_ready", 128'(ready), 128'(0));
        check("midreset_rdvalid", 128'(rdValid), 128'(0));
        check("midreset_rdkey", rdKey, 128'h0);
        tick();
        check("reset_load_dropped", 128'(busy), 128'(0));
        run_load(rand_key(), 0);
        for (int i = 0; i <= NR; i++) read_model(i);

        // Out-of-range indices while ready, then a valid read
        read_model(11);
        read_model(15);
        read_model(10);

        // Random keys and random read order
        for (int n = 0; n < 4; n++) begin
            run_load(rand_key(), (n == 1) ? int'($urandom_range(1, NR - 1)) : 0);
            for (int j = 0; j < 6; j++) read_model(int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
